// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
//   Shared definitions for the iterative RV32M multiply/divide sequencer:
//   funct3 op codes, the 2-bit FSM state encoding and small op-decode helpers.
//   Imported by muldiv_seq.
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

   // funct3 encodings of the RV32M ops
   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Remainder ops: result is the remainder register, sign follows dividend.
   function automatic logic is_rem(input logic [2:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || is_rem(op);
   endfunction

   // Ops whose result is the upper half of the 2*XLEN product.
   function automatic logic is_mul_hi(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   // rs1 is interpreted as two's complement.
   function automatic logic signed_a(input logic [2:0] op);
      logic s;
      s = 1'b0;
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
         default:                                    s = 1'b0;
      endcase
      return s;
   endfunction

   // rs2 is interpreted as two's complement (MULHSU treats rs2 as unsigned).
   function automatic logic signed_b(input logic [2:0] op);
      logic s;
      s = 1'b0;
      case (op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
         default:                         s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_seq_addsub.sv
// -----------------------------------------------------------------------------
// muldiv_addsub
//   WIDTH-bit adder/subtractor shared by the multiply accumulate step and the
//   divide trial subtraction. The sequencer feeds it XLEN+1-bit operands (one
//   extension bit above the XLEN datapath).
// Ports
//   a_i       in   WIDTH  minuend / addend
//   b_i       in   WIDTH  subtrahend / addend
//   sub_i     in   1      1: a_i - b_i, 0: a_i + b_i
//   sum_o     out  WIDTH  result (modulo 2**WIDTH)
//   borrow_o  out  1      subtraction borrowed (a_i < b_i); 0 when adding
// -----------------------------------------------------------------------------
module muldiv_addsub #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             borrow_o
);

   logic [WIDTH-1:0] b_eff;
   logic             carry;

   // Subtraction as a + ~b + 1; carry out of the top is "no borrow".
   assign b_eff = sub_i ? ~b_i : b_i;
   assign {carry, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
   assign borrow_o = sub_i & ~carry;

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Iterative RV32M multiply/divide sequencer. One shared XLEN+1-bit add/sub
//   step per clock for XLEN clocks (shift-add multiply, restoring divide),
//   followed by a sign/half-select fix-up cycle. Result is returned over a
//   valid/ready handshake; the pipeline stalls on in_ready/out_valid.
//
// Build option
//   MULDIV_DIV_EN  defined  : DIV/DIVU/REM/REMU execute, out_err always 0.
//                  undefined: divide logic removed; ops 4-7 return 0 with
//                             out_err=1 after one cycle. Multiply unchanged.
//
// Parameters
//   XLEN   operand/result width (only 32 is exercised)
//   CNT_W  iteration counter width, 2**CNT_W > XLEN
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-high reset
//   kill       in   1     abort in-flight op, back to IDLE next edge
//   in_valid   in   1     request valid
//   in_ready   out  1     high only in IDLE
//   in_op      in   3     funct3 (MUL..REMU)
//   in_a       in   XLEN  rs1
//   in_b       in   XLEN  rs2
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer accepts result
//   out_result out  XLEN  result, stable while out_valid && !out_ready
//   out_err    out  1     op unsupported in this build
// -----------------------------------------------------------------------------
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_err
);

   // ---------------------------------------------------------------------
   // State
   //   acc_q : multiply high half / divide partial remainder
   //   lo_q  : multiplier shifting out, product low half shifting in /
   //           dividend shifting out, quotient shifting in
   //   b_q   : multiplicand / divisor magnitude
   //   neg_q : final result must be negated
   // ---------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [2:0]        op_q,    op_d;
   logic [XLEN-1:0]   acc_q,   acc_d;
   logic [XLEN-1:0]   lo_q,    lo_d;
   logic [XLEN-1:0]   b_q,     b_d;
   logic              neg_q,   neg_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [XLEN-1:0]   res_q,   res_d;
   logic              err_q,   err_d;
   logic              vld_q,   vld_d;

   // Operand magnitudes and result sign, decoded from the request.
   logic              sa, sb;
   logic [XLEN-1:0]   a_abs, b_abs;

   assign sa    = signed_a(in_op) & in_a[XLEN-1];
   assign sb    = signed_b(in_op) & in_b[XLEN-1];
   assign a_abs = sa ? ({XLEN{1'b0}} - in_a) : in_a;
   assign b_abs = sb ? ({XLEN{1'b0}} - in_b) : in_b;

   // ---------------------------------------------------------------------
   // Shared add/sub step
   // ---------------------------------------------------------------------
   logic [XLEN:0]     as_a, as_b, as_sum;
   logic              as_sub, as_borrow;
   logic [XLEN:0]     mul_sum;

`ifdef MULDIV_DIV_EN
   // Divide: trial subtract divisor from {remainder, next dividend bit}.
   assign as_sub = is_div(op_q);
   assign as_a   = as_sub ? {acc_q, lo_q[XLEN-1]} : {1'b0, acc_q};
`else
   logic addsub_unused;
   assign as_sub        = 1'b0;
   assign as_a          = {1'b0, acc_q};
   assign addsub_unused = as_borrow;
`endif
   assign as_b = {1'b0, b_q};

   muldiv_addsub #(
      .WIDTH (XLEN + 1)
   ) u_addsub (
      .a_i      (as_a),
      .b_i      (as_b),
      .sub_i    (as_sub),
      .sum_o    (as_sum),
      .borrow_o (as_borrow)
   );

   // Multiply: accumulate only when the current multiplier bit is set.
   assign mul_sum = lo_q[0] ? as_sum : {1'b0, acc_q};

   // ---------------------------------------------------------------------
   // Fix-up negations. The 2*XLEN negate of {acc,lo} only carries into the
   // high half when the low half is zero.
   // ---------------------------------------------------------------------
   logic [XLEN-1:0]   lo_neg, hi_neg, acc_neg;

   assign lo_neg  = {XLEN{1'b0}} - lo_q;
   assign hi_neg  = ~acc_q + {{(XLEN-1){1'b0}}, (lo_q == '0)};
   assign acc_neg = {XLEN{1'b0}} - acc_q;

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      b_d     = b_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      vld_d   = vld_q;

      if (kill) begin
         state_d = S_IDLE;
         vld_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_d  = in_op;
                  err_d = 1'b0;
                  cnt_d = CNT_W'(XLEN - 1);
                  // Quotient sign is sa^sb, remainder sign follows dividend.
                  neg_d = is_rem(in_op) ? sa : (sa ^ sb);
                  if (is_div(in_op)) begin
`ifdef MULDIV_DIV_EN
                     if (in_b == '0) begin
                        // Preload the architectural divide-by-zero answers
                        // so FIX just selects them unmodified.
                        acc_d   = in_a;
                        lo_d    = '1;
                        b_d     = in_b;
                        neg_d   = 1'b0;
                        state_d = S_FIX;
                     end else begin
                        acc_d   = '0;
                        lo_d    = a_abs;
                        b_d     = b_abs;
                        state_d = S_CALC;
                     end
`else
                     res_d   = '0;
                     err_d   = 1'b1;
                     state_d = S_DONE;
`endif
                  end else begin
                     acc_d   = '0;
                     lo_d    = b_abs;
                     b_d     = a_abs;
                     state_d = S_CALC;
                  end
               end
            end

            S_CALC: begin
`ifdef MULDIV_DIV_EN
               if (is_div(op_q)) begin
                  if (!as_borrow) begin
                     acc_d = as_sum[XLEN-1:0];
                     lo_d  = {lo_q[XLEN-2:0], 1'b1};
                  end else begin
                     // Restore: keep the shifted remainder, quotient bit 0.
                     acc_d = as_a[XLEN-1:0];
                     lo_d  = {lo_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  acc_d = mul_sum[XLEN:1];
                  lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
               end
`else
               acc_d = mul_sum[XLEN:1];
               lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
`endif
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            S_FIX: begin
               if (is_mul_hi(op_q)) begin
                  res_d = neg_q ? hi_neg : acc_q;
               end else if (is_rem(op_q)) begin
                  res_d = neg_q ? acc_neg : acc_q;
               end else begin
                  res_d = neg_q ? lo_neg : lo_q;
               end
               state_d = S_DONE;
            end

            S_DONE: begin
               // out_valid is registered, so it rises one edge after DONE
               // is entered; the handshake only counts once it is visible.
               if (!vld_q) begin
                  vld_d = 1'b1;
               end else if (out_ready) begin
                  vld_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = vld_q;
   assign out_result = res_q;
   assign out_err    = err_q;

endmodule
